mmio_periph: RTL

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/mmio_pkg.sv | 26 ++
 rtl/sync_edge.sv | 43 ++++
 rtl/mmio_periph.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped board peripheral: register offsets,
// button bit positions and the hex-entry digit helper.
package mmio_pkg;

  localparam logic [7:0] ADDR_LED      = 8'h00;
  localparam logic [7:0] ADDR_SWT      = 8'h04;
  localparam logic [7:0] ADDR_SEG_RDY  = 8'h08;
  localparam logic [7:0] ADDR_SEG_DATA = 8'h0C;
  localparam logic [7:0] ADDR_SWX_VLD  = 8'h10;
  localparam logic [7:0] ADDR_SWX_DATA = 8'h14;
  localparam logic [7:0] ADDR_CNT      = 8'h18;

  localparam int BTN_C = 4;
  localparam int BTN_U = 3;
  localparam int BTN_L = 2;
  localparam int BTN_R = 1;
  localparam int BTN_D = 0;

  localparam int SW_W  = 16;
  localparam int BTN_W = 5;

  function automatic logic [31:0] push_digit(input logic [31:0] b, input logic [3:0] d);
    return {b[27:0], d};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered level and rise/fall pulses.
// Edge reporting stays off after reset until the history holds a real sample.
module sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] r_hist;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [STAGES:0]  r_vld;

  // r_vld marks how far real samples have propagated since reset release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) r_sync[k] <= '0;
      r_hist <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_vld  <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_hist <= r_sync[STAGES-1];
      r_vld  <= {r_vld[STAGES-1:0], 1'b1};
      r_rise <= r_vld[STAGES] ? (r_sync[STAGES-1] & ~r_hist) : '0;
      r_fall <= r_vld[STAGES] ? (~r_sync[STAGES-1] & r_hist) : '0;
    end
  end

  assign o_level = r_hist;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/mmio_periph.sv
// Board I/O peripheral on the CPU's MMIO bus: LEDs, switches/buttons,
// 7-segment data, a switch-driven hex-entry buffer and a free-running counter.
module mmio_periph
  import mmio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [15:0] led,
  output logic [31:0] seg_out
);

  logic [SW_W-1:0]  w_sw_level, w_sw_rise, w_sw_fall, w_sw_tog;
  logic [BTN_W-1:0] w_btn_level, w_btn_rise, w_btn_fall;
  logic [31:0]      w_buf_shift;
  logic             w_any_tog, w_commit, w_backspace;
  logic             w_wr_led, w_wr_seg, w_wr_cnt, w_rd_swx;
  logic             w_unused;

  logic [15:0] r_led;
  logic [31:0] r_seg_out;
  logic        r_seg_rdy;
  logic [31:0] r_buf;
  logic [31:0] r_swx_data;
  logic        r_swx_vld;
  logic [31:0] r_cnt;

  sync_edge #(.WIDTH(SW_W), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (sw),
    .o_level (w_sw_level),
    .o_rise  (w_sw_rise),
    .o_fall  (w_sw_fall)
  );

  sync_edge #(.WIDTH(BTN_W), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (btn),
    .o_level (w_btn_level),
    .o_rise  (w_btn_rise),
    .o_fall  (w_btn_fall)
  );

  assign w_sw_tog    = w_sw_rise | w_sw_fall;
  assign w_any_tog   = |w_sw_tog;
  assign w_commit    = w_btn_rise[BTN_C];
  assign w_backspace = w_btn_rise[BTN_L] & ~w_any_tog;
  assign w_wr_led    = io_we && (io_addr == ADDR_LED);
  assign w_wr_seg    = io_we && (io_addr == ADDR_SEG_DATA);
  assign w_wr_cnt    = io_we && (io_addr == ADDR_CNT);
  assign w_rd_swx    = io_rd && (io_addr == ADDR_SWX_DATA);
  assign w_unused    = ^{w_btn_fall, w_btn_rise[BTN_U], w_btn_rise[BTN_D]};

  // Simultaneous switch toggles enter as digits in ascending switch order
  always_comb begin
    w_buf_shift = r_buf;
    for (int i = 0; i < SW_W; i++) begin
      if (w_sw_tog[i]) w_buf_shift = push_digit(w_buf_shift, i[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led     <= '0;
      r_seg_out <= '0;
      r_seg_rdy <= 1'b1;
    end else begin
      if (w_wr_led) r_led <= io_dout[15:0];
      if (w_wr_seg) begin
        r_seg_out <= io_dout;
        r_seg_rdy <= 1'b0;
      end else if (w_btn_rise[BTN_R]) begin
        r_seg_rdy <= 1'b1;
      end
    end
  end

  // A commit takes the pre-shift buffer and outranks a same-cycle read-clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf      <= '0;
      r_swx_data <= '0;
      r_swx_vld  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_swx_data <= r_buf;
        r_swx_vld  <= 1'b1;
        r_buf      <= '0;
      end else begin
        if (w_rd_swx) r_swx_vld <= 1'b0;
        if (w_any_tog) r_buf <= w_buf_shift;
        else if (w_backspace) r_buf <= r_buf >> 4;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else if (w_wr_cnt) r_cnt <= io_dout;
    else r_cnt <= r_cnt + 32'd1;
  end

  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_SWT:      io_din = {11'b0, w_btn_level, w_sw_level};
      ADDR_SEG_RDY:  io_din = {31'b0, r_seg_rdy};
      ADDR_SWX_VLD:  io_din = {31'b0, r_swx_vld};
      ADDR_SWX_DATA: io_din = r_swx_data;
      ADDR_CNT:      io_din = r_cnt;
      default:       io_din = '0;
    endcase
  end

  assign led     = r_led;
  assign seg_out = r_seg_out;

endmodule
